// File: rtl/data_memory_sweep.sv
// data_memory_sweep: parametrised word-addressed data memory with registered
// reads and a one-word-per-cycle clear sweep launched by reset or by `clear`.
// While the sweep runs, `busy` is high and any incoming request is discarded
// and reported through a one-cycle `req_drop` pulse.
module data_memory_sweep #(
  parameter int DATA_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  req_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? SWEEP : IDLE;
  localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  req_drop_q, req_drop_d;
  logic                  busy_q, busy_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Next-state and access decode: clear beats req in IDLE, sweep owns the array otherwise.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    req_drop_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = address;
    mem_wdata  = data_in;

    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d    = SWEEP;
          ptr_d      = '0;
          req_drop_d = req;
        end else if (req) begin
          if (write) begin
            mem_we = 1'b1;
          end else begin
            data_out_d = mem[address];
            rd_valid_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        mem_we     = 1'b1;
        mem_waddr  = ptr_q;
        mem_wdata  = '0;
        req_drop_d = req;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

    busy_d = (state_d == SWEEP);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
      busy_q     <= RESET_BUSY;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      req_drop_q <= req_drop_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; reset keeps re-zeroing word 0 while the sweep pointer is parked there.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) begin
        mem[0] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign req_drop = req_drop_q;

endmodule

// File: tb/tb_data_memory_sweep.sv
// Directed testbench for data_memory_sweep: default instance (sweep on reset)
// plus a CLEAR_ON_RESET=0 instance sharing the access bus but with its own reset.
module tb_data_memory_sweep;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_b;
  logic       req;
  logic       write;
  logic [3:0] address;
  logic [3:0] data_in;
  logic       clear;

  logic [3:0] data_out,   data_out_b;
  logic       rd_valid,   rd_valid_b;
  logic       busy,       busy_b;
  logic       req_drop,   req_drop_b;

  int checks   = 0;
  int failures = 0;

  data_memory_sweep u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .clear    (clear),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .req_drop (req_drop)
  );

  data_memory_sweep #(.CLEAR_ON_RESET(0)) u_dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .req      (req),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .clear    (clear),
    .data_out (data_out_b),
    .rd_valid (rd_valid_b),
    .busy     (busy_b),
    .req_drop (req_drop_b)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    req = 1'b1; write = 1'b1; address = a; data_in = d;
    tick();
    req = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    req = 1'b1; write = 1'b0; address = a;
    tick();
    req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Counts cycles with busy high, starting with the current cycle; bounded at 100.
  task automatic count_busy(output int cnt, output bit quiet_ok);
    cnt = 0;
    quiet_ok = 1'b1;
    while (busy === 1'b1 && cnt < 100) begin
      if (rd_valid !== 1'b0 || data_out !== 4'h0) quiet_ok = 1'b0;
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt;
    bit quiet;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || data_out !== 4'h0 || req_drop !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b rd_valid=%b data_out=%h req_drop=%b, want 1 0 0 0",
               busy, rd_valid, data_out, req_drop);
    end
    reset = 1'b0;
    count_busy(cnt, quiet);
    checks++;
    if (cnt !== 16) begin
      failures++;
      $display("[TB] FAIL reset_busy_len: got %0d cycles, want 16", cnt);
    end
    checks++;
    if (quiet !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_quiet: rd_valid/data_out disturbed during sweep, got %b want 1", quiet);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      checks++;
      if (data_out !== 4'h0 || rd_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_readback[%0d]: data=%h valid=%b, want 0 1", i, data_out, rd_valid);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(4'd3, 4'hA);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_no_valid: rd_valid=%b want 0", rd_valid);
    end
    do_read(4'd3);
    checks++;
    if (data_out !== 4'hA || rd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_read: data=%h valid=%b, want a 1", data_out, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 4'hA) begin
      failures++;
      $display("[TB] FAIL valid_pulse: valid=%b data=%h, want 0 a", rd_valid, data_out);
    end
    do_write(4'd3, 4'h5);
    checks++;
    if (data_out !== 4'hA || rd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_holds_dout: data=%h valid=%b, want a 0", data_out, rd_valid);
    end
    do_read(4'd3);
    checks++;
    if (data_out !== 4'h5) begin
      failures++;
      $display("[TB] FAIL overwrite_read: data=%h want 5", data_out);
    end
  endtask

  task automatic test_back_to_back();
    do_write(4'd1, 4'hB);
    do_write(4'd2, 4'hC);
    do_read(4'd1);
    checks++;
    if (data_out !== 4'hB || rd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first: data=%h valid=%b, want b 1", data_out, rd_valid);
    end
    do_read(4'd2);
    checks++;
    if (data_out !== 4'hC || rd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_second: data=%h valid=%b, want c 1", data_out, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end: valid=%b want 0", rd_valid);
    end
  endtask

  task automatic test_clear();
    int cnt;
    bit quiet;
    for (int i = 0; i < 16; i++) do_write(4'(i), 4'(i));
    do_read(4'd15);
    checks++;
    if (data_out !== 4'hF) begin
      failures++;
      $display("[TB] FAIL fill_check: data=%h want f", data_out);
    end
    do_read(4'd0);
    pulse_clear();
    count_busy(cnt, quiet);
    checks++;
    if (cnt !== 16) begin
      failures++;
      $display("[TB] FAIL clear_busy_len: got %0d cycles, want 16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      checks++;
      if (data_out !== 4'h0 || rd_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL clear_readback[%0d]: data=%h valid=%b, want 0 1", i, data_out, rd_valid);
      end
    end
  endtask

  task automatic test_drop_during_sweep();
    int cnt;
    bit quiet;
    do_write(4'd4, 4'h9);
    do_read(4'd4);
    pulse_clear();
    repeat (4) tick();
    do_read(4'd4);
    checks++;
    if (req_drop !== 1'b1 || rd_valid !== 1'b0 || data_out !== 4'h9) begin
      failures++;
      $display("[TB] FAIL drop_read: drop=%b valid=%b data=%h, want 1 0 9", req_drop, rd_valid, data_out);
    end
    do_write(4'd0, 4'hC);
    checks++;
    if (req_drop !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_write: drop=%b want 1", req_drop);
    end
    tick();
    checks++;
    if (req_drop !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_pulse_end: drop=%b busy=%b, want 0 1", req_drop, busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy(cnt, quiet);
    checks++;
    if (cnt !== 8) begin
      failures++;
      $display("[TB] FAIL sweep_remaining: got %0d cycles, want 8", cnt);
    end
    do_read(4'd0);
    checks++;
    if (data_out !== 4'h0) begin
      failures++;
      $display("[TB] FAIL dropped_write_addr0: data=%h want 0", data_out);
    end
  endtask

  task automatic test_clear_and_write();
    int cnt;
    bit quiet;
    clear = 1'b1; req = 1'b1; write = 1'b1; address = 4'd7; data_in = 4'hF;
    tick();
    clear = 1'b0; req = 1'b0; write = 1'b0;
    checks++;
    if (req_drop !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clear_wins: drop=%b busy=%b, want 1 1", req_drop, busy);
    end
    count_busy(cnt, quiet);
    do_read(4'd7);
    checks++;
    if (data_out !== 4'h0 || rd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clear_wins_read: data=%h valid=%b, want 0 1", data_out, rd_valid);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    bit quiet;
    do_write(4'd5, 4'h3);
    do_read(4'd5);
    pulse_clear();
    repeat (8) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || data_out !== 4'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_state: busy=%b data=%h, want 1 0", busy, data_out);
    end
    reset = 1'b0;
    count_busy(cnt, quiet);
    checks++;
    if (cnt !== 16) begin
      failures++;
      $display("[TB] FAIL mid_reset_busy_len: got %0d cycles, want 16", cnt);
    end
  endtask

  task automatic test_no_clear_reset();
    reset_b = 1'b0;
    tick();
    checks++;
    if (busy_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nc_idle: busy=%b want 0", busy_b);
    end
    do_write(4'd2, 4'h6);
    reset_b = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy_b !== 1'b0 || rd_valid_b !== 1'b0 || data_out_b !== 4'h0) begin
      failures++;
      $display("[TB] FAIL nc_reset_state: busy=%b valid=%b data=%h, want 0 0 0", busy_b, rd_valid_b, data_out_b);
    end
    reset_b = 1'b0;
    tick();
    checks++;
    if (busy_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nc_after_reset: busy=%b want 0", busy_b);
    end
    do_read(4'd2);
    checks++;
    if (data_out_b !== 4'h6 || rd_valid_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nc_contents_kept: data=%h valid=%b, want 6 1", data_out_b, rd_valid_b);
    end
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    req = 1'b0; write = 1'b0; address = '0; data_in = '0; clear = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_drop_during_sweep();
    test_clear_and_write();
    test_reset_mid_sweep();
    test_no_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_sweep.md
Name: data_memory_sweep

Overview:
- Parametrised successor to the nibble CPU's 4-bit x 16 data memory. Width and depth are configurable.
- Reads are registered and flagged with a valid strobe.
- The single-cycle bulk reset is replaced by a multi-cycle clear sweep (one word per cycle), started by reset or by a software `clear` request. A `busy` flag stalls the core during the sweep.
- Sits between the CPU datapath and its load/store unit.

Parameters:
- DATA_WIDTH, 4, bits per word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (derived, not overridable).
- CLEAR_ON_RESET, 1: 1 = reset launches a clear sweep; 0 = reset only resets control state and leaves contents untouched.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled at posedge.
- write  input  1  with req: 1 = write, 0 = read.
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- clear  input  1  request to zero the whole array.
- data_out  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse, data_out holds fresh read data.
- busy  output  1  clear sweep in progress; requests are not accepted.
- req_drop  output  1  one-cycle pulse, a req arrived while busy and was discarded.

Behaviour:
- Only clk is used. All outputs are registered.
- Reset values: data_out=0, rd_valid=0, req_drop=0, sweep pointer=0.
  - CLEAR_ON_RESET=1: state=SWEEP, busy=1.
  - CLEAR_ON_RESET=0: state=IDLE, busy=0.
- FSM states: IDLE, SWEEP.
- While reset is high: the pointer is held at 0 and memory[0] is written with 0 each edge (when CLEAR_ON_RESET=1). No other word is written.
- IDLE, clear=1 at edge k:
  - Go to SWEEP, pointer=0, busy=1 after edge k.
  - memory[i] <= 0 at edge k+1+i, for i = 0..DEPTH-1.
  - The edge that writes word DEPTH-1 returns the FSM to IDLE, with busy=0 after it. busy is high for exactly DEPTH cycles.
- Sweep after reset release: reset low first sampled at edge r; word i is zeroed at edge r+i (word 0 again at r). busy falls after edge r+DEPTH-1.
- IDLE, req=1, write=1: memory[address] <= data_in at that edge. data_out unchanged, rd_valid=0.
- IDLE, req=1, write=0: data_out <= memory[address] and rd_valid=1 after that edge (latency 1). rd_valid clears on the next edge unless another read is accepted. data_out holds its last value between reads and is never forced to 0 on writes.
- Write then read of the same address on consecutive cycles returns the new data. At most one access per cycle, so there is no same-cycle hazard.
- clear and req in the same IDLE cycle: clear wins, the req is discarded, req_drop=1 next cycle.
- req while in SWEEP: no memory access, rd_valid=0, req_drop=1 for one cycle per dropped request.
- clear while in SWEEP: ignored (no restart).
- reset mid-sweep: the sweep restarts from word 0 per the reset rules. Words already zeroed stay zero.
- Address arithmetic: the pointer is ADDR_WIDTH bits wide. Terminal count is compared explicitly, so there is no wrap past DEPTH-1.

Test Plan:
- Reset held 3 cycles, then released (defaults) -> busy high exactly 16 cycles after release; rd_valid=0, data_out=0 throughout; all 16 words read back 0x0.
- Write 0xA to addr 3, next cycle read addr 3 -> one cycle later data_out=0xA, rd_valid=1 for one cycle; a following write of 0x5 to addr 3 leaves data_out=0xA.
- Fill addr 0..15 with value=addr, pulse clear, read all -> busy 16 cycles, then every read returns 0x0.
- Read issued during sweep (cycle 5 of 16) -> req_drop pulses once, rd_valid stays 0, memory unchanged by the request.
- clear+write to addr 7 with 0xF in the same cycle -> write discarded, req_drop=1, addr 7 reads 0x0 after the sweep.
- Reset asserted at sweep cycle 9 for 1 cycle -> sweep restarts at word 0 and busy lasts 16 cycles after release. Also run with CLEAR_ON_RESET=0: reset leaves 0x6 at addr 2 intact and busy stays 0.
